jdv_map_controller: RTL and testbench
=====================================

Name: jdv_map_controller

Overview:
- Owns the Game-of-Life cell map that feeds the VGA grid renderer: `vecteur_map`, plus the cursor position.
- Edits the map from pulsed buttons while stopped.
- While running, computes one generation every GEN_PERIOD frames, one cell per clock, into a shadow map.
- Commits the shadow map only at the frame-start edge of vga_vs, so the renderer never shows a half-updated map.

Parameters:
- GRID_W, 4, grid width in cells (≥2).
- GRID_H, 4, grid height in cells (≥2).
- GEN_PERIOD, 30, frames per generation while running (≥1).

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  asynchronous, active-high reset.
- vga_vs  in  1  vertical sync from the generator; active-low pulse at frame start.
- btn_up  in  1  one-cycle pulse; cursor y-1.
- btn_down  in  1  one-cycle pulse; cursor y+1.
- btn_left  in  1  one-cycle pulse; cursor x-1.
- btn_right  in  1  one-cycle pulse; cursor x+1.
- btn_toggle  in  1  one-cycle pulse; invert the cell under the cursor (edit only).
- btn_run  in  1  one-cycle pulse; start/stop evolution.
- vecteur_map  out  GRID_W*GRID_H  cell map; bit index = x + y*GRID_W; 1 = live.
- h_position_du_curseur  out  32  cursor x.
- v_position_du_curseur  out  32  cursor y.
- running  out  1  high in RUN/COMPUTE/PENDING.
- gen_count  out  16  generations committed since reset; wraps 0xFFFF→0.

Behaviour:
- Reset (async, immediate): vecteur_map=0, shadow=0, cursor=(0,0), state=EDIT, running=0, gen_count=0, frame_cnt=0, cell index=0, vs_d=1.
- Frame tick: vs_d registers vga_vs; tick = vs_d & !vga_vs (falling edge), one cycle per frame.
- Cursor moves in every state.
  - Saturating: x in 0..GRID_W-1, y in 0..GRID_H-1; left at x=0 and right at x=GRID_W-1 are ignored, same for y.
  - Opposing pulses in the same cycle cancel on that axis.
  - Registered: the new position is visible the cycle after the pulse.
- EDIT:
  - btn_toggle inverts vecteur_map[x + y*GRID_W] using the cursor value before any same-cycle move.
  - btn_run → RUN with frame_cnt=0. If btn_toggle and btn_run arrive together, the toggle applies, then RUN.
- RUN:
  - On each tick, frame_cnt increments.
  - On a tick with frame_cnt==GEN_PERIOD-1: frame_cnt←0, idx←0, go to COMPUTE.
  - btn_toggle is ignored.
- COMPUTE, one cycle per cell, idx 0..N-1 with N=GRID_W*GRID_H:
  - Neighbour count (4-bit, 0..8) is taken from vecteur_map, which is frozen during compute.
  - Out-of-grid neighbours count as dead.
  - shadow[idx] = (count==3) | (vecteur_map[idx] & count==2).
  - After idx==N-1 → PENDING.
  - Ticks during COMPUTE still increment frame_cnt. GEN_PERIOD ≥ N-frames is not possible with frame ≫ N cycles, so no overrun handling is needed.
- PENDING:
  - On the next tick: vecteur_map←shadow, gen_count+1, frame_cnt+1 (that tick counts as a frame), → RUN.
- btn_run in RUN/COMPUTE/PENDING: abort immediately → EDIT. Shadow is discarded, vecteur_map unchanged, frame_cnt←0.
- Latency: generation committed at the first tick ≥N cycles after the GEN_PERIOD-th tick since run start or last commit.
- Reset mid-COMPUTE/PENDING: all state returns to reset values; no partial commit.

Optional Feature:
- Macro: TORUS_WRAP_EN.
- Defined: the neighbour lookup wraps modulo GRID_W/GRID_H; the left of x=0 is x=GRID_W-1 and above y=0 is y=GRID_H-1.
- Undefined: out-of-grid neighbours are dead (default).
- Cursor movement stays saturating in both builds.

Test Plan (GRID 4x4, GEN_PERIOD=2, vga_vs pulses every 800 clks):
- Cursor saturation: reset; left×2, up×1 → cursor (0,0). Then right×5 → x=3. Simultaneous left+right → x unchanged.
- Edit: toggle at (1,0), (1,1), (1,2) → vecteur_map=0x0222. Toggle (1,1) again → 0x0202.
- Blinker: map 0x0222; run. After the 2nd tick + compute, at the next tick → 0x0070, gen_count=1. Two periods later → 0x0222, gen_count=2.
- Edge, no wrap: map 0x0888, run → commit 0x00C0. With TORUS_WRAP_EN → 0x00D0.
- Abort: map 0x0222; run; pulse btn_run during COMPUTE → state EDIT, running=0, map stays 0x0222, gen_count unchanged. btn_toggle while RUN → no map change.
- Async reset asserted in PENDING → all outputs at reset values in the same cycle. No commit on the following tick after reset is released.

Source files
------------

// File: rtl/jdv_map_controller.sv
// Game-of-Life map controller: cursor editing, periodic generation compute into a
// shadow map, commit on frame start. Define TORUS_WRAP_EN for wrap-around neighbours.
module jdv_map_controller #(
  parameter int GRID_W     = 4,
  parameter int GRID_H     = 4,
  parameter int GEN_PERIOD = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vga_vs,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_toggle,
  input  logic                       btn_run,
  output logic [GRID_W*GRID_H-1:0]   vecteur_map,
  output logic [31:0]                h_position_du_curseur,
  output logic [31:0]                v_position_du_curseur,
  output logic                       running,
  output logic [15:0]                gen_count
);

  localparam int N  = GRID_W * GRID_H;
  localparam int IW = $clog2(N);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int FW = $clog2(GEN_PERIOD + 2);

  typedef enum logic [1:0] {EDIT, RUN, COMPUTE, PENDING} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    map_q, map_d, shadow_q, shadow_d;
  logic [XW-1:0]   cur_x_q, cur_x_d;
  logic [YW-1:0]   cur_y_q, cur_y_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [15:0]     gen_q, gen_d;
  logic            running_q, running_d;
  logic            vs_q, vs_d;
  logic            tick;
  logic [IW-1:0]   cur_idx;
  logic [3:0]      nbr_cnt;
  logic            next_cell;
  int              cell_x, cell_y, nb_x, nb_y;

  // Neighbour count for the cell at idx_q, read from the live map (frozen while computing).
  always_comb begin
    cell_x  = int'(idx_q) % GRID_W;
    cell_y  = int'(idx_q) / GRID_W;
    nb_x    = 0;
    nb_y    = 0;
    nbr_cnt = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i != 4) begin
        nb_x = cell_x + int'(i % 3) - 1;
        nb_y = cell_y + int'(i / 3) - 1;
`ifdef TORUS_WRAP_EN
        nb_x    = (nb_x + GRID_W) % GRID_W;
        nb_y    = (nb_y + GRID_H) % GRID_H;
        nbr_cnt = nbr_cnt + 4'(map_q[IW'(nb_y * GRID_W + nb_x)]);
`else
        if (nb_x >= 0 && nb_x < GRID_W && nb_y >= 0 && nb_y < GRID_H)
          nbr_cnt = nbr_cnt + 4'(map_q[IW'(nb_y * GRID_W + nb_x)]);
`endif
      end
    end
    next_cell = (nbr_cnt == 4'd3) | (map_q[idx_q] & (nbr_cnt == 4'd2));
  end

  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    shadow_d = shadow_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    gen_d    = gen_q;
    vs_d     = vga_vs;
    tick     = vs_q & ~vga_vs;
    cur_idx  = IW'(int'(cur_y_q) * GRID_W + int'(cur_x_q));

    if (btn_left && !btn_right && cur_x_q != '0)
      cur_x_d = cur_x_q - XW'(1);
    else if (btn_right && !btn_left && cur_x_q != XW'(GRID_W - 1))
      cur_x_d = cur_x_q + XW'(1);
    if (btn_up && !btn_down && cur_y_q != '0)
      cur_y_d = cur_y_q - YW'(1);
    else if (btn_down && !btn_up && cur_y_q != YW'(GRID_H - 1))
      cur_y_d = cur_y_q + YW'(1);

    case (state_q)
      EDIT: begin
        if (btn_toggle) map_d[cur_idx] = ~map_q[cur_idx];
        if (btn_run) begin
          state_d = RUN;
          frame_d = '0;
        end
      end
      RUN: begin
        if (btn_run) begin
          state_d = EDIT;
          frame_d = '0;
        end else if (tick) begin
          if (frame_q >= FW'(GEN_PERIOD - 1)) begin
            frame_d = '0;
            idx_d   = '0;
            state_d = COMPUTE;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      COMPUTE: begin
        if (btn_run) begin
          state_d = EDIT;
          frame_d = '0;
        end else begin
          shadow_d[idx_q] = next_cell;
          if (idx_q == IW'(N - 1)) state_d = PENDING;
          else                     idx_d   = idx_q + IW'(1);
          if (tick) frame_d = frame_q + FW'(1);
        end
      end
      PENDING: begin
        if (btn_run) begin
          state_d = EDIT;
          frame_d = '0;
        end else if (tick) begin
          map_d   = shadow_q;
          gen_d   = gen_q + 16'd1;
          frame_d = frame_q + FW'(1);
          state_d = RUN;
        end
      end
      default: state_d = EDIT;
    endcase

    running_d = (state_d != EDIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EDIT;
      map_q     <= '0;
      shadow_q  <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      gen_q     <= '0;
      running_q <= 1'b0;
      vs_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      shadow_q  <= shadow_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      gen_q     <= gen_d;
      running_q <= running_d;
      vs_q      <= vs_d;
    end
  end

  assign vecteur_map           = map_q;
  assign h_position_du_curseur = 32'(cur_x_q);
  assign v_position_du_curseur = 32'(cur_y_q);
  assign running               = running_q;
  assign gen_count             = gen_q;

endmodule

// File: tb/tb_jdv_map_controller.sv
// Scoreboard bench for jdv_map_controller: 4x4 grid, two frames per generation,
// vga_vs pulsing every 800 clocks.
`timescale 1ns/1ps
module tb_jdv_map_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_vs = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_toggle = 1'b0, btn_run = 1'b0;
  logic [15:0] vecteur_map;
  logic [31:0] h_position_du_curseur, v_position_du_curseur;
  logic        running;
  logic [15:0] gen_count;

  localparam logic [5:0] B_UP = 6'b100000, B_DN = 6'b010000, B_LF = 6'b001000;
  localparam logic [5:0] B_RT = 6'b000100, B_TG = 6'b000010, B_RN = 6'b000001;
`ifdef TORUS_WRAP_EN
  localparam logic [15:0] EDGE_MAP = 16'h00D0;
`else
  localparam logic [15:0] EDGE_MAP = 16'h00C0;
`endif

  typedef struct {
    string       name;
    logic [15:0] map;
    int unsigned x;
    int unsigned y;
    logic        run;
    logic [15:0] gen;
  } snap_t;

  typedef struct {
    logic [15:0] map;
    logic [15:0] gen;
  } commit_t;

  snap_t       snap_q[$];
  commit_t     commit_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_gen = '0;

  jdv_map_controller #(.GRID_W(4), .GRID_H(4), .GEN_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .vga_vs(vga_vs),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_toggle(btn_toggle), .btn_run(btn_run),
    .vecteur_map(vecteur_map),
    .h_position_du_curseur(h_position_du_curseur),
    .v_position_du_curseur(v_position_du_curseur),
    .running(running), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (798) @(posedge clk);
      #1 vga_vs = 1'b0;
      repeat (2) @(posedge clk);
      #1 vga_vs = 1'b1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
    $fatal(1);
  end

  // Monitor: snapshot requests and every gen_count change are checked against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        last_gen = gen_count;
      end else if (gen_count !== last_gen) begin
        checks++;
        if (commit_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected: got map=%h gen=%0d, want no commit", vecteur_map, gen_count);
        end else begin
          commit_t c;
          c = commit_q.pop_front();
          if (vecteur_map !== c.map || gen_count !== c.gen) begin
            errors++;
            $display("FAIL commit: got map=%h gen=%0d, want map=%h gen=%0d",
                     vecteur_map, gen_count, c.map, c.gen);
          end
        end
        last_gen = gen_count;
      end
      while (snap_q.size() > 0) begin
        snap_t s;
        s = snap_q.pop_front();
        checks++;
        if (vecteur_map !== s.map || h_position_du_curseur !== s.x ||
            v_position_du_curseur !== s.y || running !== s.run || gen_count !== s.gen) begin
          errors++;
          $display("FAIL %s: got map=%h x=%0d y=%0d run=%b gen=%0d, want map=%h x=%0d y=%0d run=%b gen=%0d",
                   s.name, vecteur_map, h_position_du_curseur, v_position_du_curseur, running,
                   gen_count, s.map, s.x, s.y, s.run, s.gen);
        end
      end
    end
  end

  task automatic expect_state(input string nm, input logic [15:0] m, input int unsigned x,
                              input int unsigned y, input logic r, input logic [15:0] g);
    snap_t s;
    s.name = nm; s.map = m; s.x = x; s.y = y; s.run = r; s.gen = g;
    snap_q.push_back(s);
  endtask

  task automatic expect_commit(input logic [15:0] m, input logic [15:0] g);
    commit_t c;
    c.map = m; c.gen = g;
    commit_q.push_back(c);
  endtask

  task automatic pulse(input logic [5:0] b);
    @(posedge clk);
    #1 {btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_run} = b;
    @(posedge clk);
    #1 {btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_run} = '0;
  endtask

  task automatic wait_fall();
    int n;
    n = 0;
    while (vga_vs === 1'b0 && n < 2000) begin @(posedge clk); n++; end
    while (vga_vs !== 1'b0 && n < 2000) begin @(posedge clk); n++; end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL vs_timeout: waited %0d cycles, want fewer than 2000", n);
    end
  endtask

  task automatic wait_ticks(input int unsigned n, input int unsigned post);
    repeat (n) wait_fall();
    repeat (post) @(posedge clk);
  endtask

  // Park just after a frame tick so the next one is ~800 clocks away.
  task automatic sync_frame();
    wait_fall();
    repeat (5) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 expect_state("reset", 16'h0000, 0, 0, 1'b0, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    pulse(B_LF); pulse(B_LF); pulse(B_UP);
    expect_state("sat_min", 16'h0000, 0, 0, 1'b0, 16'd0);
    repeat (5) pulse(B_RT);
    expect_state("sat_max", 16'h0000, 3, 0, 1'b0, 16'd0);
    pulse(B_LF | B_RT);
    expect_state("cancel_lr", 16'h0000, 3, 0, 1'b0, 16'd0);
    pulse(B_UP | B_DN);
    expect_state("cancel_ud", 16'h0000, 3, 0, 1'b0, 16'd0);

    pulse(B_LF); pulse(B_LF); pulse(B_TG);
    expect_state("tog_1_0", 16'h0002, 1, 0, 1'b0, 16'd0);
    pulse(B_DN); pulse(B_TG); pulse(B_DN); pulse(B_TG);
    expect_state("tog_column", 16'h0222, 1, 2, 1'b0, 16'd0);
    pulse(B_UP); pulse(B_TG);
    expect_state("retoggle", 16'h0202, 1, 1, 1'b0, 16'd0);
    pulse(B_TG | B_DN);
    expect_state("tog_pre_move", 16'h0222, 1, 2, 1'b0, 16'd0);
    pulse(B_UP);

    sync_frame();
    expect_commit(16'h0070, 16'd1);
    expect_commit(16'h0222, 16'd2);
    pulse(B_RN);
    expect_state("run_start", 16'h0222, 1, 1, 1'b1, 16'd0);
    wait_ticks(3, 40);
    expect_state("blinker_g1", 16'h0070, 1, 1, 1'b1, 16'd1);
    wait_ticks(2, 40);
    expect_state("blinker_g2", 16'h0222, 1, 1, 1'b1, 16'd2);
    pulse(B_RN);
    expect_state("stop", 16'h0222, 1, 1, 1'b0, 16'd2);

    sync_frame();
    pulse(B_RN);
    pulse(B_TG);
    expect_state("tog_in_run", 16'h0222, 1, 1, 1'b1, 16'd2);
    wait_fall();
    wait_fall();
    repeat (3) @(posedge clk);
    pulse(B_RN);
    expect_state("abort_compute", 16'h0222, 1, 1, 1'b0, 16'd2);
    wait_ticks(2, 40);
    expect_state("abort_no_commit", 16'h0222, 1, 1, 1'b0, 16'd2);

    pulse(B_UP); pulse(B_TG); pulse(B_DN); pulse(B_TG); pulse(B_DN); pulse(B_TG);
    pulse(B_RT); pulse(B_RT); pulse(B_TG); pulse(B_UP); pulse(B_TG); pulse(B_UP);
    expect_state("edge_setup", 16'h0880, 3, 0, 1'b0, 16'd2);
    sync_frame();
    expect_commit(EDGE_MAP, 16'd3);
    pulse(B_TG | B_RN);
    expect_state("tog_and_run", 16'h0888, 3, 0, 1'b1, 16'd2);
    wait_ticks(3, 40);
    expect_state("edge_gen", EDGE_MAP, 3, 0, 1'b1, 16'd3);
    pulse(B_RN);
    expect_state("edge_stop", EDGE_MAP, 3, 0, 1'b0, 16'd3);

    sync_frame();
    pulse(B_RN);
    expect_state("run_again", EDGE_MAP, 3, 0, 1'b1, 16'd3);
    wait_ticks(2, 40);
    @(posedge clk);
    #2 reset = 1'b1;
    expect_state("reset_pending", 16'h0000, 0, 0, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(2, 40);
    expect_state("after_reset", 16'h0000, 0, 0, 1'b0, 16'd0);

    repeat (5) @(posedge clk);
    checks++;
    if (commit_q.size() != 0) begin
      errors++;
      $display("FAIL commits_outstanding: got %0d uncommitted generations, want 0", commit_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
